i2c_xfer_seq: RTL and testbench



---
 rtl/i2c_xfer_seq.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_seq.sv
// Register-access sequencer for the i2c_master io bus.
// Turns single-byte register read/write requests into command sequences.
module i2c_xfer_seq #(
  parameter logic [15:0] PRESCALE = 16'd99,
  parameter logic [19:0] TIMEOUT  = 20'd100000,
  parameter int          RD_LAT   = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [4:0] io_a,
  output logic [7:0] io_di,
  input  logic [7:0] io_do,
  output logic       io_we,
  output logic       io_re
);

  localparam logic [7:0] LAT = 8'(RD_LAT);

  typedef enum logic [3:0] {
    INIT_PL, INIT_PH, INIT_EN, IDLE,
    WR_TXR, WR_CR, POLL_RE, POLL_WAIT,
    POLL_CHK, RD_RXR, RXR_WAIT, STOP_CR,
    RST0, RST1, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        wbusy_q, wbusy_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  lat_q, lat_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rx_q, rx_d;
  logic [4:0]  io_a_q, io_a_d;
  logic [7:0]  io_di_q, io_di_d;
  logic        io_we_q, io_we_d;
  logic        io_re_q, io_re_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;

  logic [7:0] txr_v, cr_v;
  logic       last_wr, timed_out;

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign io_a      = io_a_q;
  assign io_di     = io_di_q;
  assign io_we     = io_we_q;
  assign io_re     = io_re_q;

  assign last_wr   = !rnw_q && (step_q == 2'd2);
  assign timed_out = (cnt_q >= TIMEOUT);

  // Step 3 is the read-data command, which has no TXR byte.
  always_comb begin
    txr_v = {dev_q, 1'b0};
    cr_v  = 8'h90;
    unique case (step_q)
      2'd0: begin
        txr_v = {dev_q, 1'b0};
        cr_v  = 8'h90;
      end
      2'd1: begin
        txr_v = reg_q;
        cr_v  = 8'h10;
      end
      2'd2: begin
        txr_v = rnw_q ? {dev_q, 1'b1} : wdata_q;
        cr_v  = rnw_q ? 8'h90 : 8'h50;
      end
      default: begin
        txr_v = reg_q;
        cr_v  = 8'h68;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rnw_d       = rnw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    wbusy_d     = wbusy_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    err_d       = err_q;
    rx_d        = rx_q;
    io_a_d      = io_a_q;
    io_di_d     = io_di_q;
    io_we_d     = 1'b0;
    io_re_d     = 1'b0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      INIT_PL: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd0;
        io_di_d = PRESCALE[7:0];
        state_d = INIT_PH;
      end
      INIT_PH: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd1;
        io_di_d = PRESCALE[15:8];
        state_d = INIT_EN;
      end
      INIT_EN: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd2;
        io_di_d = 8'h80;
        state_d = IDLE;
      end
      IDLE: begin
        if (req_valid && ready_q) begin
          rnw_d   = req_rnw;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          step_d  = 2'd0;
          err_d   = 2'd0;
          wbusy_d = 1'b0;
          state_d = WR_TXR;
        end else begin
          ready_d = 1'b1;
        end
      end
      WR_TXR: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd3;
        io_di_d = txr_v;
        state_d = WR_CR;
      end
      WR_CR: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd5;
        io_di_d = cr_v;
        cnt_d   = 20'd0;
        state_d = POLL_RE;
      end
      POLL_RE: begin
        io_re_d = 1'b1;
        io_a_d  = 5'd6;
        cnt_d   = cnt_q + 20'd1;
        lat_d   = 8'd1;
        state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (lat_q == LAT) state_d = POLL_CHK;
        else lat_d = lat_q + 8'd1;
      end
      POLL_CHK: begin
        if (wbusy_q) begin
          if (!io_do[6]) begin
            state_d = DONE;
          end else if (timed_out) begin
            err_d   = 2'd3;
            state_d = RST0;
          end else begin
            state_d = POLL_RE;
          end
        end else if (io_do[1]) begin
          if (timed_out) begin
            err_d   = 2'd3;
            state_d = RST0;
          end else begin
            state_d = POLL_RE;
          end
        end else if (io_do[5]) begin
          err_d   = 2'd2;
          state_d = DONE;
        end else if (step_q == 2'd3) begin
          state_d = RD_RXR;
        end else if (io_do[7]) begin
          err_d   = 2'd1;
          state_d = last_wr ? DONE : STOP_CR;
        end else if (last_wr) begin
          state_d = DONE;
        end else if (step_q == 2'd2) begin
          step_d  = 2'd3;
          state_d = WR_CR;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = WR_TXR;
        end
      end
      RD_RXR: begin
        io_re_d = 1'b1;
        io_a_d  = 5'd4;
        lat_d   = 8'd0;
        state_d = RXR_WAIT;
      end
      RXR_WAIT: begin
        if (lat_q == LAT) begin
          rx_d    = io_do;
          state_d = DONE;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      STOP_CR: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd5;
        io_di_d = 8'h40;
        cnt_d   = 20'd0;
        wbusy_d = 1'b1;
        state_d = POLL_RE;
      end
      RST0: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd2;
        io_di_d = 8'h00;
        state_d = RST1;
      end
      RST1: begin
        io_we_d = 1'b1;
        io_a_d  = 5'd2;
        io_di_d = 8'h80;
        state_d = DONE;
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (rnw_q && err_q == 2'd0) rdata_d = rx_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = INIT_PL;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= INIT_PL;
      step_q      <= 2'd0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wdata_q     <= 8'd0;
      wbusy_q     <= 1'b0;
      cnt_q       <= 20'd0;
      lat_q       <= 8'd0;
      err_q       <= 2'd0;
      rx_q        <= 8'd0;
      io_a_q      <= 5'd0;
      io_di_q     <= 8'd0;
      io_we_q     <= 1'b0;
      io_re_q     <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'd0;
      rsp_err_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rnw_q       <= rnw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      wbusy_q     <= wbusy_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      err_q       <= err_d;
      rx_q        <= rx_d;
      io_a_q      <= io_a_d;
      io_di_q     <= io_di_d;
      io_we_q     <= io_we_d;
      io_re_q     <= io_re_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Bench for i2c_xfer_seq: emulated i2c_master plus slave,
// checked against a transaction-level reference model.
module tb_i2c_xfer_seq;

  localparam logic [15:0] PRE = 16'h1234;
  localparam logic [6:0]  SLV = 7'h50;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       req_valid, req_ready, req_rnw;
  logic [6:0] req_dev;
  logic [7:0] req_reg, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [4:0] io_a;
  logic [7:0] io_di, io_do;
  logic       io_we, io_re;

  always #5 clk = ~clk;

  i2c_xfer_seq #(
    .PRESCALE(PRE),
    .TIMEOUT(20'd8),
    .RD_LAT(1)
  ) dut (
    .sys_clk(clk),
    .sys_rst(sys_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rnw(req_rnw),
    .req_dev(req_dev),
    .req_reg(req_reg),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .io_a(io_a),
    .io_di(io_di),
    .io_do(io_do),
    .io_we(io_we),
    .io_re(io_re)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // emulated i2c_master + slave state
  logic [7:0]  mem [256];
  logic [7:0]  exp_mem [256];
  logic [7:0]  txr_m, rxr_m, ptr;
  logic [12:0] obs [$];
  logic [12:0] exp_q [$];
  int  tip_left, cmd_idx, byte_idx, phase;
  int  nack_k, stuck_at;
  int  sr_reads, sr_since_cr, sr_at_rst, rxr_reads, both_cnt;
  int  cyc;
  bit  stuck, bus_busy, al_now, nack_bit, al_force, sel, stop_seen;

  initial begin
    tip_left = 0; cmd_idx = 0; byte_idx = 0; phase = 0;
    nack_k = -1; stuck_at = -1; sr_reads = 0; sr_since_cr = 0;
    sr_at_rst = -1; rxr_reads = 0; both_cnt = 0; cyc = 0;
    stuck = 0; bus_busy = 0; al_now = 0; nack_bit = 0;
    al_force = 0; sel = 0; stop_seen = 0;
    txr_m = 0; rxr_m = 0; ptr = 0;
  end

  task automatic do_cmd(input logic [7:0] cr);
    sr_since_cr = 0;
    tip_left = $urandom_range(0, 4);
    al_now = 0;
    if (cmd_idx == stuck_at) stuck = 1;
    cmd_idx++;
    if (cr[7]) begin
      bus_busy = 1;
      if (al_force) begin
        al_now = 1;
        al_force = 0;
        bus_busy = 0;
      end
    end
    if (cr[4]) begin
      if (cr[7]) begin
        sel = (txr_m[7:1] == SLV);
        phase = txr_m[0] ? 3 : 1;
      end
      nack_bit = !(sel && byte_idx != nack_k);
      if (!nack_bit && !cr[7]) begin
        if (phase == 1) begin
          ptr = txr_m;
          phase = 2;
        end else if (phase == 2) begin
          mem[ptr] = txr_m;
        end
      end
      byte_idx++;
    end
    if (cr[5]) rxr_m = mem[ptr];
    if (cr[6]) begin
      bus_busy = 0;
      stop_seen = 1;
    end
  endtask

  initial begin
    io_do = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (sys_rst) begin
        tip_left = 0;
        stuck = 0;
        bus_busy = 0;
        al_now = 0;
        io_do <= 8'h00;
      end else begin
        if (io_we && io_re) both_cnt++;
        if (io_we) begin
          obs.push_back({io_a, io_di});
          if (io_a == 5'd3) txr_m = io_di;
          else if (io_a == 5'd5) do_cmd(io_di);
          else if (io_a == 5'd2 && io_di == 8'h00) begin
            stuck = 0;
            sr_at_rst = sr_since_cr;
          end
        end
        if (io_re && io_a == 5'd6) begin
          sr_reads++;
          sr_since_cr++;
          io_do <= {nack_bit, bus_busy || tip_left > 0 || stuck, al_now,
                    3'b000, tip_left > 0 || stuck, 1'b0};
          if (tip_left > 0) tip_left--;
        end else if (io_re && io_a == 5'd4) begin
          rxr_reads++;
          io_do <= rxr_m;
        end
      end
    end
  end

  // reference model: expected io write list and outcome per request
  logic [1:0] exp_err;
  logic [7:0] exp_rd, last_rd;
  int         exp_rxr;

  function automatic void push_exp(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endfunction

  task automatic model(input bit rnw, input logic [6:0] dev,
                       input logic [7:0] rg, input logic [7:0] wd,
                       input int nk, input int sa, input bit al);
    logic [7:0] tx [3];
    logic [7:0] cr [3];
    tx[0] = {dev, 1'b0}; cr[0] = 8'h90;
    tx[1] = rg;          cr[1] = 8'h10;
    tx[2] = rnw ? {dev, 1'b1} : wd;
    cr[2] = rnw ? 8'h90 : 8'h50;
    exp_q.delete();
    exp_err = 0;
    exp_rxr = 0;
    exp_rd = last_rd;
    for (int k = 0; k < 3; k++) begin
      push_exp(5'd3, tx[k]);
      push_exp(5'd5, cr[k]);
      if (sa == k) begin
        push_exp(5'd2, 8'h00);
        push_exp(5'd2, 8'h80);
        exp_err = 3;
        return;
      end
      if (al && k == 0) begin
        exp_err = 2;
        return;
      end
      if ((k == 0 && dev != SLV) || nk == k) begin
        exp_err = 1;
        if (rnw || k != 2) push_exp(5'd5, 8'h40);
        return;
      end
    end
    if (rnw) begin
      push_exp(5'd5, 8'h68);
      if (sa == 3) begin
        push_exp(5'd2, 8'h00);
        push_exp(5'd2, 8'h80);
        exp_err = 3;
        return;
      end
      exp_rxr = 1;
      exp_rd = exp_mem[rg];
    end else begin
      exp_mem[rg] = wd;
    end
  endtask

  task automatic run_req(input bit rnw, input logic [6:0] dev,
                         input logic [7:0] rg, input logic [7:0] wd,
                         input int nk, input int sa, input bit al);
    bit ok;
    int cyc_acc;
    int n;
    @(negedge clk);
    nack_k = nk; stuck_at = sa; al_force = al;
    byte_idx = 0; cmd_idx = 0; stop_seen = 0;
    sr_reads = 0; rxr_reads = 0; sr_at_rst = -1;
    obs.delete();
    model(rnw, dev, rg, wd, nk, sa, al);
    req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
    req_valid = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    cyc_acc = cyc;
    req_rnw = 1'($urandom); req_dev = 7'($urandom);
    req_reg = 8'($urandom); req_wdata = 8'($urandom);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rsp_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    last_rd = exp_rd;
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rdy_at_rsp", req_ready, 1);
    chk("n_writes", obs.size(), exp_q.size());
    n = obs.size() < exp_q.size() ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("io_wr", obs[i], exp_q[i]);
    chk("rxr_reads", rxr_reads, exp_rxr);
    if (exp_err == 3) chk("to_polls", sr_at_rst, 8);
    if (!rnw && exp_err == 0) begin
      chk("overhead", cyc - cyc_acc, 7 + 3 * sr_reads);
      chk("slave_mem", mem[rg], wd);
      chk("stop_seen", stop_seen, 1);
    end
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_we", io_we, 0);
    chk("rst_re", io_re, 0);
    chk("rst_a", io_a, 0);
    chk("rst_di", io_di, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
  endtask

  task automatic check_init();
    logic [7:0] d [3];
    d[0] = PRE[7:0];
    d[1] = PRE[15:8];
    d[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("init_we", io_we, 1);
      chk("init_a", io_a, i);
      chk("init_di", io_di, d[i]);
      chk("init_rdy", req_ready, 0);
    end
    @(negedge clk);
    chk("rdy_rise", req_ready, 1);
    chk("idle_we", io_we, 0);
  endtask

  initial begin
    bit ok;
    int sc, sa, nk;
    bit rnw, al;
    logic [6:0] dev;
    sys_rst = 1;
    req_valid = 0; req_rnw = 0; req_dev = 0; req_reg = 0; req_wdata = 0;
    last_rd = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check_reset_vals();
    sys_rst = 0;
    check_init();

    run_req(0, SLV, 8'h0A, 8'hC3, -1, -1, 0);
    mem[8'h0A] = 8'h5E;
    exp_mem[8'h0A] = 8'h5E;
    run_req(1, SLV, 8'h0A, 8'h00, -1, -1, 0);
    run_req(0, 7'h21, 8'h03, 8'h77, -1, -1, 0);
    run_req(0, SLV, 8'h04, 8'h11, -1, -1, 1);
    run_req(1, SLV, 8'h05, 8'h00, -1, 0, 0);
    run_req(0, SLV, 8'h06, 8'h99, -1, -1, 0);
    run_req(0, SLV, 8'h07, 8'h42, 2, -1, 0);

    for (int t = 0; t < 40; t++) begin
      rnw = 1'($urandom);
      dev = SLV;
      nk = -1; sa = -1; al = 0;
      sc = $urandom_range(0, 9);
      if (sc == 5) nk = $urandom_range(0, 2);
      else if (sc == 6) dev = SLV ^ 7'($urandom_range(1, 127));
      else if (sc == 7) al = 1;
      else if (sc == 8) sa = $urandom_range(0, rnw ? 3 : 2);
      run_req(rnw, dev, 8'($urandom_range(0, 7)), 8'($urandom),
              nk, sa, al);
    end

    // reset in the middle of a read poll
    @(negedge clk);
    req_rnw = 1; req_dev = SLV; req_reg = 8'h02; req_valid = 1;
    nack_k = -1; stuck_at = -1; al_force = 0; byte_idx = 0; cmd_idx = 0;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!req_ready) req_valid = 0;
      if (io_re && io_a == 5'd6) begin
        ok = 1;
        break;
      end
    end
    chk("midrst_poll_seen", ok, 1);
    req_valid = 0;
    #1 sys_rst = 1;
    #1;
    chk("midrst_re", io_re, 0);
    chk("midrst_we", io_we, 0);
    @(negedge clk);
    check_reset_vals();
    last_rd = 8'h00;
    sys_rst = 0;
    check_init();
    run_req(1, SLV, 8'h03, 8'h00, -1, -1, 0);

    chk("we_re_both", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
